// File: rtl/alu_issue.sv
// Two-stage RV32I ALU issue pipeline: decode into D, drive external ALU, capture result in W.
// Optional one-entry skid buffer in front of D when ALU_ISSUE_SKID_EN is defined.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        alu_op_imm,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  input  logic [31:0] alu_t,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_rd,
  output logic [31:0] out_result,
  output logic        out_illegal
);

  typedef struct packed {
    logic        op_imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic        ill;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr,
                                  input logic [31:0] rs1,
                                  input logic [31:0] rs2);
    dec_t       r;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       shift;
    r     = '0;
    f3    = instr[14:12];
    f7    = instr[31:25];
    shift = (f3 == 3'b001) || (f3 == 3'b101);
    r.funct3 = f3;
    r.rd     = instr[11:7];
    r.a      = rs1;
    case (instr[6:0])
      7'b0110011: begin
        r.op_imm = 1'b0;
        r.funct7 = f7;
        r.b      = shift ? {27'd0, rs2[4:0]} : rs2;
        r.ill    = !((f7 == 7'b0000000) || (f7 == 7'b0100000)) ||
                   ((f7 == 7'b0100000) && !((f3 == 3'b000) || (f3 == 3'b101)));
      end
      7'b0010011: begin
        r.op_imm = 1'b1;
        r.funct7 = shift ? f7 : 7'd0;
        r.b      = shift ? {27'd0, instr[24:20]} : {{20{instr[31]}}, instr[31:20]};
        r.ill    = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                   ((f3 == 3'b101) && (f7 != 7'b0000000) && (f7 != 7'b0100000));
      end
      default: r.ill = 1'b1;
    endcase
    return r;
  endfunction

  dec_t        in_dec;
  dec_t        d_q, d_d;
  logic        d_vld_q, d_vld_d;
  logic        w_vld_q, w_vld_d;
  logic [4:0]  w_rd_q, w_rd_d;
  logic [31:0] w_res_q, w_res_d;
  logic        w_ill_q, w_ill_d;
  logic        w_can, d_adv, d_free, accept;
  logic        unused_rs1_field;

  assign unused_rs1_field = ^in_instr[19:15];
  assign in_dec = decode(in_instr, in_rs1, in_rs2);

  // W accepts when empty or draining; D has room when empty or advancing.
  assign w_can  = !w_vld_q || out_ready;
  assign d_adv  = d_vld_q && w_can;
  assign d_free = !d_vld_q || w_can;
  assign accept = in_valid && in_ready;

`ifdef ALU_ISSUE_SKID_EN
  dec_t s_q, s_d;
  logic s_vld_q, s_vld_d;
  logic rdy_q, rdy_d;

  assign in_ready = rdy_q;

  always_comb begin
    s_d     = s_q;
    s_vld_d = s_vld_q;
    d_d     = d_q;
    d_vld_d = d_vld_q && !d_adv;
    if (d_free) begin
      if (s_vld_q) begin
        d_d     = s_q;
        d_vld_d = 1'b1;
        s_vld_d = 1'b0;
      end else if (accept) begin
        d_d     = in_dec;
        d_vld_d = 1'b1;
      end
    end else if (accept) begin
      s_d     = in_dec;
      s_vld_d = 1'b1;
    end
    rdy_d = !s_vld_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q     <= '0;
      s_vld_q <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      s_q     <= s_d;
      s_vld_q <= s_vld_d;
      rdy_q   <= rdy_d;
    end
  end
`else
  assign in_ready = !rst && d_free;

  always_comb begin
    d_d     = d_q;
    d_vld_d = d_vld_q;
    if (accept) begin
      d_d     = in_dec;
      d_vld_d = 1'b1;
    end else if (d_adv) begin
      d_vld_d = 1'b0;
    end
  end
`endif

  // D -> W: result forced to zero for illegal entries and writes to x0.
  always_comb begin
    w_vld_d = w_vld_q;
    w_rd_d  = w_rd_q;
    w_res_d = w_res_q;
    w_ill_d = w_ill_q;
    if (w_can) begin
      w_vld_d = d_vld_q;
      if (d_vld_q) begin
        w_rd_d  = d_q.rd;
        w_ill_d = d_q.ill;
        w_res_d = (d_q.ill || (d_q.rd == 5'd0)) ? 32'd0 : alu_t;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_q     <= '0;
      d_vld_q <= 1'b0;
      w_vld_q <= 1'b0;
      w_rd_q  <= 5'd0;
      w_res_q <= 32'd0;
      w_ill_q <= 1'b0;
    end else begin
      d_q     <= d_d;
      d_vld_q <= d_vld_d;
      w_vld_q <= w_vld_d;
      w_rd_q  <= w_rd_d;
      w_res_q <= w_res_d;
      w_ill_q <= w_ill_d;
    end
  end

  assign alu_op_imm  = d_q.op_imm;
  assign alu_funct3  = d_q.funct3;
  assign alu_funct7  = d_q.funct7;
  assign alu_a       = d_q.a;
  assign alu_b       = d_q.b;

  assign out_valid   = w_vld_q;
  assign out_rd      = w_rd_q;
  assign out_result  = w_res_q;
  assign out_illegal = w_ill_q;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with an instruction-level reference model and scoreboard.
module tb_alu_issue;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr, in_rs1, in_rs2;
  logic        alu_op_imm;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [31:0] alu_a, alu_b, alu_t;
  logic        out_valid, out_ready;
  logic [4:0]  out_rd;
  logic [31:0] out_result;
  logic        out_illegal;

  int total = 0;
  int bad   = 0;
  logic [37:0] expq[$];

  alu_issue dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .alu_op_imm(alu_op_imm), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .alu_a(alu_a), .alu_b(alu_b), .alu_t(alu_t),
    .out_valid(out_valid), .out_ready(out_ready), .out_rd(out_rd),
    .out_result(out_result), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  // External ALU; shifts use the whole b operand, so b must arrive already masked.
  always_comb begin
    alu_t = 32'd0;
    case (alu_funct3)
      3'd0: alu_t = (!alu_op_imm && alu_funct7[5]) ? alu_a - alu_b : alu_a + alu_b;
      3'd1: alu_t = alu_a << alu_b;
      3'd2: alu_t = {31'd0, $signed(alu_a) < $signed(alu_b)};
      3'd3: alu_t = {31'd0, alu_a < alu_b};
      3'd4: alu_t = alu_a ^ alu_b;
      3'd5: if (alu_funct7[5]) alu_t = $signed(alu_a) >>> alu_b;
            else alu_t = alu_a >> alu_b;
      3'd6: alu_t = alu_a | alu_b;
      default: alu_t = alu_a & alu_b;
    endcase
  end

  // Reference: {illegal, rd, result} straight from RV32I semantics.
  function automatic logic [37:0] model(input logic [31:0] ins, r1, r2);
    logic [6:0]  op, f7;
    logic [2:0]  f3;
    logic [4:0]  rd, sh;
    logic [31:0] b, res;
    logic        ill;
    op = ins[6:0]; f3 = ins[14:12]; f7 = ins[31:25]; rd = ins[11:7];
    res = 32'd0;
    if (op == 7'h33) begin
      b = r2;
      ill = !((f7 == 7'h00) || ((f7 == 7'h20) && (f3 == 3'd0 || f3 == 3'd5)));
    end else if (op == 7'h13) begin
      b = {{20{ins[31]}}, ins[31:20]};
      ill = (f3 == 3'd1 && f7 != 7'h00) || (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20);
    end else begin
      b = 32'd0;
      ill = 1'b1;
    end
    sh = b[4:0];
    case (f3)
      3'd0: res = (op == 7'h33 && f7 == 7'h20) ? r1 - b : r1 + b;
      3'd1: res = r1 << sh;
      3'd2: res = ($signed(r1) < $signed(b)) ? 32'd1 : 32'd0;
      3'd3: res = (r1 < b) ? 32'd1 : 32'd0;
      3'd4: res = r1 ^ b;
      3'd5: if (f7 == 7'h20) res = $signed(r1) >>> sh;
            else res = r1 >> sh;
      3'd6: res = r1 | b;
      default: res = r1 & b;
    endcase
    if (ill || rd == 5'd0) res = 32'd0;
    return {ill, rd, res};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2, rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'h33};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd);
    return {imm, rs1, f3, rd, 7'h13};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_out(input string nm);
    int n;
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    if (!out_valid) chk(nm, 32'(out_valid), 32'd1);
  endtask

  // Scoreboard: evaluated mid-cycle, when handshakes for the next edge are settled.
  always @(negedge clk) begin
    if (rst) begin
      expq.delete();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_rd", 32'(out_rd), 32'd0);
      chk("rst_out_result", out_result, 32'd0);
      chk("rst_out_illegal", 32'(out_illegal), 32'd0);
    end else begin
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_out_valid", 32'(out_valid), 32'd0);
        end else begin
          chk("sb_rd", 32'(out_rd), 32'(expq[0][36:32]));
          chk("sb_result", out_result, expq[0][31:0]);
          chk("sb_illegal", 32'(out_illegal), 32'(expq[0][37]));
          if (out_ready) void'(expq.pop_front());
        end
      end
      if (in_valid && in_ready) expq.push_back(model(in_instr, in_rs1, in_rs2));
    end
  end

  localparam logic [31:0] I_ADDI = 32'hFFF08293;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SRA  = 32'h4020D233;
  localparam logic [31:0] I_JAL  = 32'h0000006F;
  localparam logic [31:0] I_MUL  = 32'h02208333;
  localparam logic [31:0] I_ADD0 = 32'h00208033;

  initial begin
    logic [37:0] m;
    logic [31:0] bp_ins[3];
    logic [31:0] mix_ins[16];
    logic [31:0] snap_res;
    logic [4:0]  snap_rd;
    int acc, drained, idx, cyc, exp_acc;
    logic hs;

    rst = 1'b1; in_valid = 1'b1; in_instr = I_ADDI; in_rs1 = 32'h10; in_rs2 = 32'h0;
    out_ready = 1'b1;

    m = model(I_ADDI, 32'h10, 32'h0);
    chk("pin_addi", m[31:0], 32'h0000000F);
    m = model(I_SUB, 32'h80000000, 32'h21);
    chk("pin_sub", m[31:0], 32'h7FFFFFDF);
    m = model(I_SRA, 32'h80000000, 32'h21);
    chk("pin_sra", m[31:0], 32'hC0000000);
    m = model(I_JAL, 32'h5, 32'h7);
    chk("pin_jal_ill", 32'(m[37]), 32'd1);
    m = model(I_ADD0, 32'h5, 32'h7);
    chk("pin_add_x0", m[31:0], 32'd0);

    repeat (2) step();
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_f3", 32'(alu_funct3), 32'd0);
    chk("rst_alu_f7", 32'(alu_funct7), 32'd0);
    chk("rst_alu_imm", 32'(alu_op_imm), 32'd0);
    chk("rst_in_ready_hold", 32'(in_ready), 32'd0);
    rst = 1'b0; in_valid = 1'b0;
    repeat (2) step();

    // ADDI x5,x1,-1: two-cycle latency
    in_valid = 1'b1; in_instr = I_ADDI; in_rs1 = 32'h10;
    chk("addi_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    chk("addi_lat1", 32'(out_valid), 32'd0);
    step();
    chk("addi_valid", 32'(out_valid), 32'd1);
    chk("addi_rd", 32'(out_rd), 32'd5);
    chk("addi_result", out_result, 32'h0000000F);
    chk("addi_illegal", 32'(out_illegal), 32'd0);

    // SUB then SRA back-to-back
    in_valid = 1'b1; in_instr = I_SUB; in_rs1 = 32'h80000000; in_rs2 = 32'h21;
    step();
    in_instr = I_SRA;
    step();
    in_valid = 1'b0;
    chk("sub_rd", 32'(out_rd), 32'd3);
    chk("sub_result", out_result, 32'h7FFFFFDF);
    step();
    chk("sra_valid", 32'(out_valid), 32'd1);
    chk("sra_rd", 32'(out_rd), 32'd4);
    chk("sra_result", out_result, 32'hC0000000);
    step();
    chk("sra_drained", 32'(out_valid), 32'd0);

    // JAL, OP funct7=1, ADD x0
    in_valid = 1'b1; in_instr = I_JAL; in_rs1 = 32'd5; in_rs2 = 32'd7;
    step();
    in_instr = I_MUL;
    step();
    in_instr = I_ADD0;
    chk("jal_illegal", 32'(out_illegal), 32'd1);
    chk("jal_result", out_result, 32'd0);
    step();
    in_valid = 1'b0;
    chk("mul_illegal", 32'(out_illegal), 32'd1);
    chk("mul_result", out_result, 32'd0);
    chk("mul_rd", 32'(out_rd), 32'd6);
    step();
    chk("add0_valid", 32'(out_valid), 32'd1);
    chk("add0_rd", 32'(out_rd), 32'd0);
    chk("add0_result", out_result, 32'd0);
    chk("add0_illegal", 32'(out_illegal), 32'd0);
    step();

    // Backpressure: 5 stalled cycles, 3 instructions offered
`ifdef ALU_ISSUE_SKID_EN
    exp_acc = 3;
`else
    exp_acc = 2;
`endif
    bp_ins[0] = enc_r(7'h00, 5'd2, 5'd1, 3'd0, 5'd7);
    bp_ins[1] = enc_i(12'h0F0, 5'd1, 3'd4, 5'd8);
    bp_ins[2] = enc_i(12'h00F, 5'd1, 3'd6, 5'd9);
    out_ready = 1'b0; acc = 0; snap_res = 32'd0; snap_rd = 5'd0;
    for (int c = 0; c < 5; c++) begin
      in_valid = (acc < 3);
      in_instr = bp_ins[acc < 3 ? acc : 0];
      in_rs1 = 32'd5 + 32'(acc); in_rs2 = 32'd7;
      hs = in_valid && in_ready;
      step();
      if (hs) acc++;
      if (c == 2) begin
        snap_res = out_result;
        snap_rd = out_rd;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", 32'(acc), 32'(exp_acc));
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_stall_valid", 32'(out_valid), 32'd1);
    chk("bp_stable_result", out_result, snap_res);
    chk("bp_stable_rd", 32'(out_rd), 32'(snap_rd));
    chk("bp_first_rd", 32'(out_rd), 32'd7);
    chk("bp_first_result", out_result, 32'd12);
    out_ready = 1'b1; drained = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) drained++;
      step();
    end
    chk("bp_drained", 32'(drained), 32'(acc));

    // Mixed stream with intermittent out_ready
    mix_ins[0]  = enc_i(12'hFFB, 5'd1, 3'd2, 5'd9);
    mix_ins[1]  = enc_i(12'hFFF, 5'd1, 3'd3, 5'd10);
    mix_ins[2]  = enc_i(12'h007, 5'd1, 3'd1, 5'd11);
    mix_ins[3]  = enc_i(12'h403, 5'd1, 3'd5, 5'd12);
    mix_ins[4]  = enc_i(12'h01F, 5'd1, 3'd5, 5'd13);
    mix_ins[5]  = enc_i(12'h401, 5'd1, 3'd1, 5'd14);
    mix_ins[6]  = enc_i(12'h023, 5'd1, 3'd5, 5'd15);
    mix_ins[7]  = enc_r(7'h00, 5'd2, 5'd1, 3'd1, 5'd16);
    mix_ins[8]  = enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd17);
    mix_ins[9]  = enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd18);
    mix_ins[10] = enc_r(7'h00, 5'd2, 5'd1, 3'd6, 5'd19);
    mix_ins[11] = enc_r(7'h00, 5'd2, 5'd1, 3'd7, 5'd20);
    mix_ins[12] = enc_r(7'h20, 5'd2, 5'd1, 3'd7, 5'd21);
    mix_ins[13] = enc_i(12'h123, 5'd1, 3'd0, 5'd0);
    mix_ins[14] = 32'h0000A183;
    mix_ins[15] = enc_r(7'h00, 5'd2, 5'd1, 3'd5, 5'd22);
    idx = 0; cyc = 0;
    while (idx < 16 && cyc < 300) begin
      in_valid = 1'b1;
      in_instr = mix_ins[idx];
      in_rs1 = 32'h9E3779B9 * 32'(idx + 1);
      in_rs2 = {in_rs1[15:0], ~in_rs1[31:16]};
      out_ready = (cyc % 3) != 2;
      hs = in_ready;
      step();
      if (hs) idx++;
      cyc++;
    end
    chk("mix_all_issued", 32'(idx), 32'd16);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) step();

    // Reset pulse with two entries in flight
    out_ready = 1'b0; acc = 0; cyc = 0;
    while (acc < 2 && cyc < 20) begin
      in_valid = 1'b1; in_instr = I_ADDI; in_rs1 = 32'h20 + 32'(acc);
      hs = in_ready;
      step();
      if (hs) acc++;
      cyc++;
    end
    in_valid = 1'b0;
    chk("rstp_loaded", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstp_async_valid", 32'(out_valid), 32'd0);
    chk("rstp_async_ready", 32'(in_ready), 32'd0);
    chk("rstp_async_result", out_result, 32'd0);
    step();
    rst = 1'b0; out_ready = 1'b1;
    repeat (4) step();
    chk("rstp_no_stale", 32'(out_valid), 32'd0);
    in_valid = 1'b1; in_instr = enc_i(12'd100, 5'd1, 3'd0, 5'd6); in_rs1 = 32'd1;
    chk("rstp_in_ready", 32'(in_ready), 32'd1);
    step();
    in_valid = 1'b0;
    wait_out("rstp_timeout");
    chk("rstp_rd", 32'(out_rd), 32'd6);
    chk("rstp_result", out_result, 32'h00000065);
    repeat (3) step();

    chk("scoreboard_empty", 32'(expq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock; rst  in  1  asynchronous active-high reset.
REQ-002 SHALL have ports: in_valid  in  1  instruction offered; in_ready  out  1  instruction accepted when in_valid & in_ready; in_instr  in  32  RV32I word; in_rs1  in  32  rs1 value; in_rs2  in  32  rs2 value.
REQ-003 SHALL have ports: alu_op_imm  out  1; alu_funct3  out  3; alu_funct7  out  7; alu_a  out  32; alu_b  out  32; alu_t  in  32. These form the combinational ALU datapath.
REQ-004 SHALL have ports: out_valid  out  1; out_ready  in  1; out_rd  out  5  destination register; out_result  out  32  result; out_illegal  out  1  instruction not executable by the ALU.
REQ-005 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-006 SHALL be a two-stage pipeline: D (decoded-operand register) and W (result register). Minimum accept-to-out_valid latency is 2 cycles. Throughput is 1 per cycle when out_ready=1.
REQ-007 SHALL drive the alu_* outputs only from D-stage registers, and SHALL capture alu_t into W when D advances.
REQ-008 OP (opcode 0110011) decode SHALL be: op_imm=0, funct3=instr[14:12], funct7=instr[31:25], a=rs1, b=rs2.
REQ-009 OP-IMM (opcode 0010011) decode SHALL be: op_imm=1, a=rs1, b=sign-extended instr[31:20]. funct7=instr[31:25] when funct3 is 001 or 101; otherwise funct7=0.
REQ-010 For funct3 001/101, b SHALL be zero-extended to 5 bits before D is loaded: rs2[4:0] for OP, instr[24:20] for OP-IMM.
REQ-011 SHALL mark illegal any of the following:
- any other opcode;
- OP funct7 not in {0000000, 0100000};
- OP funct7=0100000 with funct3 not in {000, 101};
- OP-IMM funct3=001 with funct7≠0;
- OP-IMM funct3=101 with funct7 not in {0000000, 0100000}.
REQ-012 An illegal entry SHALL flow through both stages with out_illegal=1 and out_result=0.
REQ-013 out_rd SHALL equal instr[11:7]. When out_rd=0, out_result SHALL be 0.
REQ-014 W SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-015 D SHALL advance into W when W is empty or W is draining (out_valid & out_ready) in the same cycle.
REQ-016 A simultaneous accept into D and advance out of D SHALL neither lose nor duplicate an entry.
REQ-017 in_ready SHALL be 0 only when D is full and D cannot advance.

Reset
REQ-018 While rst=1, in_ready SHALL be 0, and out_valid, out_illegal, out_rd and out_result SHALL all be 0.
REQ-019 While rst=1, the D registers SHALL be 0, so the ALU is driven with op_imm=0, funct3=0, funct7=0, a=0, b=0.
REQ-020 rst asserted mid-operation SHALL discard all in-flight entries. The first accept SHALL occur no earlier than the first clk edge after rst deasserts.

Configuration
REQ-021 Macro ALU_ISSUE_SKID_EN SHALL select the in_ready behaviour.
REQ-022 With ALU_ISSUE_SKID_EN defined:
- SHALL add a one-entry skid buffer in front of D;
- in_ready SHALL be a registered signal equal to "skid empty", with no combinational path from out_ready;
- an entry accepted while D is stalled SHALL park in the skid and issue in order.
REQ-023 Without ALU_ISSUE_SKID_EN, in_ready SHALL be combinational per REQ-017, and no skid storage SHALL exist.

Verification
REQ-024 ADDI x5,x1,-1 (0xFFF08293), rs1=0x00000010, out_ready=1 -> two cycles later out_valid=1, out_rd=5, out_result=0x0000000F, out_illegal=0.
REQ-025 SUB x3,x1,x2 then SRA x4,x1,x2, rs1=0x80000000, rs2=0x00000021, back-to-back -> results 0x7FFFFFDF then 0xC0000000 (shift masked to 1), on consecutive cycles.
REQ-026 Backpressure: out_ready=0 for 5 cycles while 3 valid instructions are offered ->
- without the macro: 2 accepted, in_ready=0, out_* stable;
- with the macro: 3 accepted;
- after out_ready=1: all drain in order.
REQ-027 Illegal word 0x0000006F (JAL), and OP with funct7=0000001 -> out_illegal=1, out_result=0 for each.
REQ-028 ADD x0,x1,x2 with rs1=5, rs2=7 -> out_rd=0, out_result=0.
REQ-029 Pulse rst for 1 cycle with 2 entries in flight -> out_valid=0 immediately (asynchronous). No stale entries emerge; a new ADDI completes normally afterwards.
